// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its PC register.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    // Instructions are word aligned; redirect targets drop their byte offset.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Fetch program counter: synchronous reset, redirect load, and +4 advance.
module instr_fetch_pc_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        inc,
    output logic [31:0] pc
);

    // Load wins over increment so a redirect is never lost to a same-cycle capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= align_word(load_value);
        end else if (inc) begin
            pc <= pc + 32'(WORD_BYTES);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, and
// keeps one registered instruction slot for the field splitter.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        instr_valid
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc;
    logic [31:0]  hold_addr;
    logic         slot_space;
    logic         capture;
    logic         consume;

    instr_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (redirect_valid),
        .load_value (redirect_target),
        .inc        (capture),
        .pc         (pc)
    );

    assign imem_req  = (state != HOLD);
    assign imem_addr = (state == FLUSH) ? hold_addr : pc;

    always_comb begin
        slot_space = !instr_valid || !stall;
        consume    = instr_valid && !stall;
        capture    = (state == FETCH) && imem_ack && slot_space && !redirect_valid;
    end

    // An ack that meets a full, stalled slot is dropped without advancing the PC,
    // so that word is simply fetched again once the slot drains.
    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (redirect_valid) begin
                    state_nxt = imem_ack ? FETCH : FLUSH;
                end else if (imem_ack && stall) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || !stall) begin
                    state_nxt = FETCH;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // The abandoned request keeps its address on the bus until memory acks it.
    always_ff @(posedge clk) begin
        if (state == FETCH && redirect_valid && !imem_ack) begin
            hold_addr <= pc;
        end
    end

    // Output slot
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid    <= 1'b0;
            instruction    <= NOP_WORD;
            instr_pc       <= 32'h0000_0000;
            instr_pc_plus4 <= 32'(WORD_BYTES);
        end else if (redirect_valid) begin
            instr_valid    <= 1'b0;
            instruction    <= NOP_WORD;
        end else if (capture) begin
            instr_valid    <= 1'b1;
            instruction    <= imem_rdata;
            instr_pc       <= pc;
            instr_pc_plus4 <= pc + 32'(WORD_BYTES);
        end else if (consume) begin
            instr_valid    <= 1'b0;
            instruction    <= NOP_WORD;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: handshake, stall, redirect, flush and PC wrap.
module tb_instr_fetch;

    localparam logic [31:0] K = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, imem_ack;
    logic [31:0] redirect_target;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instruction, instr_pc, instr_pc_plus4;

    logic        reset2;
    logic        imem_req2, instr_valid2;
    logic [31:0] imem_addr2, imem_rdata2, instruction2, instr_pc2, instr_pc_plus4_2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_rdata  = imem_addr ^ K;
    assign imem_rdata2 = imem_addr2 ^ K;

    instr_fetch dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instruction(instruction), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
        .instr_valid(instr_valid)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .imem_ack(1'b1),
        .instruction(instruction2), .instr_pc(instr_pc2), .instr_pc_plus4(instr_pc_plus4_2),
        .instr_valid(instr_valid2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1;
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h55; imem_ack = 1'b1;
        tick(); tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %h want 0", instr_valid); end
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", instruction); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", instr_pc); end
        n_cmp++; if (instr_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_pc4 got %h want 4", instr_pc_plus4); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rst_req got %h want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    endtask

    task automatic test_zero_wait();
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (imem_addr !== 32'(4*i)) begin n_err++; $display("FAIL zw_addr[%0d] got %h want %h", i, imem_addr, 32'(4*i)); end
            n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL zw_req[%0d] got %h want 1", i, imem_req); end
            tick();
            n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL zw_valid[%0d] got %h want 1", i, instr_valid); end
            n_cmp++; if (instr_pc !== 32'(4*i)) begin n_err++; $display("FAIL zw_pc[%0d] got %h want %h", i, instr_pc, 32'(4*i)); end
            n_cmp++; if (instruction !== (32'(4*i) ^ K)) begin n_err++; $display("FAIL zw_instr[%0d] got %h want %h", i, instruction, 32'(4*i) ^ K); end
            n_cmp++; if (instr_pc_plus4 !== 32'(4*i+4)) begin n_err++; $display("FAIL zw_pc4[%0d] got %h want %h", i, instr_pc_plus4, 32'(4*i+4)); end
        end
    endtask

    task automatic test_wait_states();
        imem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL ws_req[%0d] got %h want 1", c, imem_req); end
            n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL ws_addr[%0d] got %h want 10", c, imem_addr); end
            tick();
            n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ws_valid[%0d] got %h want 0", c, instr_valid); end
        end
        imem_ack = 1'b1;
        n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL ws_addr_ack got %h want 10", imem_addr); end
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL ws_load_valid got %h want 1", instr_valid); end
        n_cmp++; if (instr_pc !== 32'h10) begin n_err++; $display("FAIL ws_load_pc got %h want 10", instr_pc); end
        n_cmp++; if (instruction !== (32'h10 ^ K)) begin n_err++; $display("FAIL ws_load_instr got %h want %h", instruction, 32'h10 ^ K); end
        tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ws_once_valid got %h want 0", instr_valid); end
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL ws_once_instr got %h want 0", instruction); end
        n_cmp++; if (imem_addr !== 32'h14) begin n_err++; $display("FAIL ws_next_addr got %h want 14", imem_addr); end
    endtask

    task automatic test_stall();
        imem_ack = 1'b1;
        tick();
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL st_valid[%0d] got %h want 1", c, instr_valid); end
            n_cmp++; if (instr_pc !== 32'h14) begin n_err++; $display("FAIL st_pc[%0d] got %h want 14", c, instr_pc); end
            n_cmp++; if (instruction !== (32'h14 ^ K)) begin n_err++; $display("FAIL st_instr[%0d] got %h want %h", c, instruction, 32'h14 ^ K); end
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL st_req[%0d] got %h want 0", c, imem_req); end
        end
        stall = 1'b0;
        tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL st_drain_valid got %h want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL st_resume_req got %h want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h18) begin n_err++; $display("FAIL st_resume_addr got %h want 18", imem_addr); end
        tick();
        n_cmp++; if (instr_pc !== 32'h18) begin n_err++; $display("FAIL st_next_pc got %h want 18", instr_pc); end
    endtask

    task automatic test_redirect_outstanding();
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
        n_cmp++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL ro_pre_addr got %h want 20", imem_addr); end
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ro_kill_valid got %h want 0", instr_valid); end
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL ro_kill_instr got %h want 0", instruction); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL ro_flush_req got %h want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL ro_flush_addr got %h want 20", imem_addr); end
        tick();
        n_cmp++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL ro_flush_addr2 got %h want 20", imem_addr); end
        imem_ack = 1'b1;
        tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ro_discard_valid got %h want 0", instr_valid); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL ro_target_addr got %h want 100", imem_addr); end
        tick();
        n_cmp++; if (instr_pc !== 32'h100) begin n_err++; $display("FAIL ro_target_pc got %h want 100", instr_pc); end
        n_cmp++; if (instruction !== (32'h100 ^ K)) begin n_err++; $display("FAIL ro_target_instr got %h want %h", instruction, 32'h100 ^ K); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40; imem_ack = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rs_valid got %h want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rs_req got %h want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL rs_addr got %h want 40", imem_addr); end
        stall = 1'b0;
        tick();
        n_cmp++; if (instr_pc !== 32'h40) begin n_err++; $display("FAIL rs_pc got %h want 40", instr_pc); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL rs_valid2 got %h want 1", instr_valid); end
    endtask

    task automatic test_reset_flush();
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h200;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (imem_addr !== 32'h44) begin n_err++; $display("FAIL rf_flush_addr got %h want 44", imem_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rf_req got %h want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rf_addr got %h want 0", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rf_valid got %h want 0", instr_valid); end
        n_cmp++; if (instr_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rf_pc4 got %h want 4", instr_pc_plus4); end
        tick();
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rf_addr2 got %h want 0", imem_addr); end
    endtask

    task automatic test_wrap();
        reset2 = 1'b0;
        n_cmp++; if (imem_addr2 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_addr0 got %h want fffffffc", imem_addr2); end
        n_cmp++; if (imem_req2 !== 1'b1) begin n_err++; $display("FAIL wr_req got %h want 1", imem_req2); end
        tick();
        n_cmp++; if (imem_addr2 !== 32'h0) begin n_err++; $display("FAIL wr_addr1 got %h want 0", imem_addr2); end
        n_cmp++; if (instr_pc2 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_pc got %h want fffffffc", instr_pc2); end
        n_cmp++; if (instr_pc_plus4_2 !== 32'h0) begin n_err++; $display("FAIL wr_pc4 got %h want 0", instr_pc_plus4_2); end
        n_cmp++; if (instruction2 !== (32'hFFFF_FFFC ^ K)) begin n_err++; $display("FAIL wr_instr got %h want %h", instruction2, 32'hFFFF_FFFC ^ K); end
        n_cmp++; if (instr_valid2 !== 1'b1) begin n_err++; $display("FAIL wr_valid got %h want 1", instr_valid2); end
        tick();
        n_cmp++; if (instr_pc2 !== 32'h0) begin n_err++; $display("FAIL wr_pc2 got %h want 0", instr_pc2); end
        n_cmp++; if (imem_addr2 !== 32'h4) begin n_err++; $display("FAIL wr_addr2 got %h want 4", imem_addr2); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_outstanding();
        test_redirect_stall();
        test_reset_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
